// File: rtl/imply_commit_pkg.sv
// imply_commit shared types: pin encoding, null variable, FSM states.
// Pin helpers are shared with the propagation side.
package imply_commit_pkg;

  localparam logic [1:0] ZERO    = 2'b00;
  localparam logic [1:0] ONE     = 2'b10;
  localparam logic [1:0] UNKNOWN = 2'b11;

  localparam int NULL_VAR = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFLICT,
    S_EMIT,
    S_DONE
  } state_e;

  // 2'b01 falls out as not-known, i.e. treated like UNKNOWN
  function automatic logic pin_known(input logic [1:0] c);
    return (c == ZERO) || (c == ONE);
  endfunction

endpackage

// File: rtl/pin_priority_enc.sv
// Lowest-set-bit encoder over a pin vector.
// Index 0 wins; any reports a non-empty request.
module pin_priority_enc #(
  parameter int N = 13,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan downwards so the lowest set bit is the last write
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/imply_commit.sv
// LUT implication commit: conflict check, then serialise new
// assignments one per cycle onto the trail writer stream.
module imply_commit
  import imply_commit_pkg::*;
#(
  parameter int LUT_SIZE = 12,
  parameter int VAR_W    = 16,
  parameter int LUT_ID_W = 16,
  localparam int NP = LUT_SIZE + 1,
  localparam int CW = $clog2(LUT_SIZE + 2),
  localparam int IW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LUT_ID_W-1:0]   in_lut_id,
  input  logic [2*LUT_SIZE+1:0] in_pins,
  input  logic [2*LUT_SIZE+1:0] in_implied,
  input  logic [NP*VAR_W-1:0]   in_vars,
  output logic                  imp_valid,
  input  logic                  imp_ready,
  output logic [VAR_W-1:0]      imp_var,
  output logic                  imp_value,
  output logic [LUT_ID_W-1:0]   imp_reason,
  output logic                  conflict_valid,
  input  logic                  conflict_ready,
  output logic [LUT_ID_W-1:0]   conflict_lut,
  output logic                  done,
  output logic [CW-1:0]         done_count,
  output logic                  busy
);

  state_e state;

  logic [LUT_ID_W-1:0]         lut_q;
  logic [NP-1:0][VAR_W-1:0]    vars_q;
  logic [NP-1:0]               val_q;
  logic [NP-1:0]               pend_q;
  logic [CW-1:0]               cnt_q;

  logic [NP-1:0] new_c;
  logic [NP-1:0] clash_c;
  logic [NP-1:0] val_c;
  logic [1:0]    p;
  logic [1:0]    m;
  logic          used;

  logic [IW-1:0] sel;
  logic          any;
  logic [NP-1:0] pend_nxt;
  logic          accept;

  // classify every pin of the offered LUT
  always_comb begin
    new_c   = '0;
    clash_c = '0;
    val_c   = '0;
    p       = '0;
    m       = '0;
    used    = 1'b0;
    for (int i = 0; i < NP; i++) begin
      p    = in_pins[2*i +: 2];
      m    = in_implied[2*i +: 2];
      used = in_vars[i*VAR_W +: VAR_W] != VAR_W'(NULL_VAR);
      new_c[i]   = used && !pin_known(p) && pin_known(m);
      clash_c[i] = used && pin_known(p) && pin_known(m) && (p != m);
      val_c[i]   = (m == ONE);
    end
  end

  pin_priority_enc #(.N(NP)) u_enc (
    .req (pend_q),
    .idx (sel),
    .any (any)
  );

  assign pend_nxt = pend_q & ~(NP'(1) << sel);
  assign in_ready = (state == S_IDLE) && !ap_rst && !flush;
  assign accept   = in_valid && in_ready;

  // job FSM; reset beats flush, flush beats everything else
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= S_IDLE;
      pend_q <= '0;
      cnt_q  <= '0;
      lut_q  <= '0;
      vars_q <= '0;
      val_q  <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            lut_q  <= in_lut_id;
            vars_q <= in_vars;
            val_q  <= val_c;
            pend_q <= new_c;
            cnt_q  <= '0;
            if (|clash_c)    state <= S_CONFLICT;
            else if (|new_c) state <= S_EMIT;
            else             state <= S_DONE;
          end
        end
        S_CONFLICT: begin
          if (conflict_ready) state <= S_DONE;
        end
        S_EMIT: begin
          if (imp_ready) begin
            pend_q <= pend_nxt;
            cnt_q  <= cnt_q + CW'(1);
            if (pend_nxt == '0) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign done_count = done ? cnt_q : '0;

  assign conflict_valid = (state == S_CONFLICT);
  assign conflict_lut   = conflict_valid ? lut_q : '0;

  assign imp_valid  = (state == S_EMIT) && any;
  assign imp_var    = imp_valid ? vars_q[sel] : '0;
  assign imp_value  = imp_valid && val_q[sel];
  assign imp_reason = imp_valid ? lut_q : '0;

endmodule
